// File: rtl/instr_buffer.sv
// instr_buffer: per-warp instruction FIFO between fetch and decode, with flush and terminal halt on EXIT
module instr_buffer #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 4,
    parameter int OP_WIDTH    = 6,
    parameter int FUNC_WIDTH  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_WIDTH-1:0]   in_instr,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_WIDTH-1:0]      out_op,
    output logic [FUNC_WIDTH-1:0]    out_func,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t                 r_state, w_next;
    logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [PC_WIDTH-1:0]    r_mem_pc    [DEPTH];
    logic [AW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count;
    logic                   w_push, w_pop, w_exit, w_clear;

    assign out_instr = r_mem_instr[r_rptr];
    assign out_pc    = r_mem_pc[r_rptr];
    assign out_op    = out_instr[INSTR_WIDTH-1 -: OP_WIDTH];
    assign out_func  = out_instr[FUNC_WIDTH-1:0];
    assign count     = r_count;

    assign w_push  = in_valid && in_ready;
    assign w_pop   = out_valid && out_ready;
    assign w_exit  = w_pop && (out_op == {OP_WIDTH{1'b1}});
    // EXIT and flush both empty the buffer and drop any same-cycle push
    assign w_clear = w_exit || (flush && r_state == RUN);

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == RUN && w_exit) w_next = HALT;
    end

    always_comb begin
        in_ready  = (r_state == RUN) && (r_count != CW'(DEPTH));
        out_valid = (r_state == RUN) && (r_count != '0);
        halted    = (r_state == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (w_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wptr] <= in_instr;
                r_mem_pc[r_wptr]    <= in_pc;
                r_wptr              <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: directed self-checking bench for instr_buffer
module tb_instr_buffer;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0, in_ready;
    logic [31:0] in_instr = 0, in_pc = 0;
    logic        flush = 0;
    logic        out_valid, out_ready = 0;
    logic [5:0]  out_op, out_func;
    logic [31:0] out_instr, out_pc;
    logic [2:0]  count;
    logic        halted;

    int n_chk = 0;
    int n_err = 0;

    instr_buffer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_func(out_func), .out_instr(out_instr), .out_pc(out_pc),
        .count(count), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h0400_0000 | pc;
    endfunction

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1; in_instr = instr; in_pc = pc;
        step();
        in_valid = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_out_op"}, out_op, 0);
        chk({tag, "_out_func"}, out_func, 0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_out_pc"}, out_pc, 0);
    endtask

    initial begin
        logic [31:0] exp_head, next_pc;
        int mcount;
        logic mpush;
        step(); step();
        rst = 0;
        chk_reset("rst0");

        // fill to capacity
        for (int k = 0; k < 4; k++) push(instr_of(32'h100 + 4 * k), 32'h100 + 4 * k);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_head_pc", out_pc, 32'h100);
        push(instr_of(32'h999), 32'h999);
        chk("full_reject_count", count, 4);
        chk("full_reject_head", out_pc, 32'h100);

        // streaming with wrap-around
        exp_head = 32'h100; next_pc = 32'h110; mcount = 4;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            in_pc = next_pc; in_instr = instr_of(next_pc);
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, exp_head);
            chk("stream_instr", out_instr, instr_of(exp_head));
            chk("stream_in_ready", in_ready, mcount != 4);
            mpush = (mcount != 4);
            step();
            exp_head += 4;
            if (mpush) next_pc += 4;
            mcount = mcount + int'(mpush) - 1;
            chk("stream_count", count, mcount);
        end
        in_valid = 0;
        while (mcount > 0) begin
            chk("drain_pc", out_pc, exp_head);
            step();
            exp_head += 4; mcount--;
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_count", count, 0);
        out_ready = 0;

        // field split, no bypass
        in_valid = 1; in_instr = 32'h0000_0003; in_pc = 32'h200;
        chk("nobypass_valid", out_valid, 0);
        step(); in_valid = 0;
        chk("add_valid", out_valid, 1);
        chk("add_op", out_op, 0);
        chk("add_func", out_func, 3);
        chk("add_pc", out_pc, 32'h200);
        out_ready = 1; step(); out_ready = 0;
        chk("add_popped", count, 0);

        // flush with simultaneous pop and push
        for (int k = 0; k < 3; k++) push(instr_of(32'h300 + 4 * k), 32'h300 + 4 * k);
        chk("fl_count3", count, 3);
        flush = 1; out_ready = 1; in_valid = 1; in_pc = 32'h3F0; in_instr = instr_of(32'h3F0);
        chk("fl_popped_pc", out_pc, 32'h300);
        step();
        flush = 0; out_ready = 0; in_valid = 0;
        chk("fl_count", count, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        step();
        chk("fl_push_dropped", count, 0);
        push(instr_of(32'h400), 32'h400);
        chk("fl_after_pc", out_pc, 32'h400);
        chk("fl_after_count", count, 1);
        out_ready = 1; step(); out_ready = 0;

        // EXIT with flush and push in the same cycle
        push(32'hFC00_0000, 32'h500);
        push(instr_of(32'h504), 32'h504);
        chk("exit_count", count, 2);
        chk("exit_op", out_op, 63);
        out_ready = 1; flush = 1; in_valid = 1; in_pc = 32'h508; in_instr = instr_of(32'h508);
        step();
        chk("halt_halted", halted, 1);
        chk("halt_in_ready", in_ready, 0);
        chk("halt_out_valid", out_valid, 0);
        chk("halt_count", count, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush = 1'($urandom_range(0, 1));
            in_instr = $urandom; in_pc = $urandom;
            step();
            chk("halt_hold_halted", halted, 1);
            chk("halt_hold_in_ready", in_ready, 0);
            chk("halt_hold_out_valid", out_valid, 0);
            chk("halt_hold_count", count, 0);
        end
        in_valid = 0; out_ready = 0; flush = 0;
        rst = 1; step(); rst = 0;
        chk_reset("rst_halt");

        // reset mid-operation with a handshake in the reset cycle
        push(instr_of(32'h600), 32'h600);
        push(instr_of(32'h604), 32'h604);
        chk("rst2_count", count, 2);
        rst = 1; in_valid = 1; out_ready = 1; in_pc = 32'h608; in_instr = instr_of(32'h608);
        step();
        rst = 0; in_valid = 0; out_ready = 0;
        chk_reset("rst_mid");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
